// File: rtl/split_pkg.sv
// split_eval shared types
// FSM states, MODE encodings, index width helper
package split_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    HOLD = 2'd2
  } state_t;

  localparam int MODE_TAUT  = 0;
  localparam int MODE_RANGE = 1;

  function automatic int idx_w(input int n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/split_bound_table.sv
// split_eval bound table
// one write port, one combinational read port
module split_bound_table
  import split_pkg::*;
#(
  parameter int NUM_VARS = 30,
  parameter int VAR_W    = 32,
  localparam int IW      = idx_w(NUM_VARS)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             we,
  input  logic [IW-1:0]    wr_idx,
  input  logic [VAR_W-1:0] wr_lo,
  input  logic [VAR_W-1:0] wr_hi,
  input  logic [IW-1:0]    rd_idx,
  output logic [VAR_W-1:0] rd_lo,
  output logic [VAR_W-1:0] rd_hi
);

  localparam int DEPTH = 1 << IW;

  logic [VAR_W-1:0] lo_mem [DEPTH];
  logic [VAR_W-1:0] hi_mem [DEPTH];
  logic             wr_ok;

  assign wr_ok = we && (int'(wr_idx) < NUM_VARS);

  // reset to always-pass bounds, otherwise take in-range writes
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        lo_mem[i] <= '0;
        hi_mem[i] <= '1;
      end
    end else if (wr_ok) begin
      lo_mem[wr_idx] <= wr_lo;
      hi_mem[wr_idx] <= wr_hi;
    end
  end

  assign rd_lo = lo_mem[rd_idx];
  assign rd_hi = hi_mem[rd_idx];

endmodule

// File: rtl/split_eval.sv
// split_eval top
// streams variables, range-checks each, reports conjunction
module split_eval
  import split_pkg::*;
#(
  parameter int NUM_VARS = 30,
  parameter int VAR_W    = 32,
  parameter int MODE     = 1,
  localparam int IW      = idx_w(NUM_VARS)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cfg_we,
  input  logic [IW-1:0]    cfg_idx,
  input  logic [VAR_W-1:0] cfg_lo,
  input  logic [VAR_W-1:0] cfg_hi,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [VAR_W-1:0] in_data,
  input  logic             in_last,
  output logic             res_valid,
  input  logic             res_ready,
  output logic             res_x,
  output logic [IW-1:0]    res_fail_idx,
  output logic             res_err
);

  if (NUM_VARS < 2 || NUM_VARS > 64) begin : g_bad_nv
    $error("split_eval: NUM_VARS must be 2..64");
  end
  if (VAR_W < 1 || VAR_W > 64) begin : g_bad_w
    $error("split_eval: VAR_W must be 1..64");
  end

  localparam logic TAUT = (MODE == MODE_TAUT);

  state_t           state;
  logic [IW-1:0]    idx;
  logic [VAR_W-1:0] lo;
  logic [VAR_W-1:0] hi;
  logic             beat;
  logic             at_max;
  logic             done;
  logic             early;
  logic             pass;
  logic             tbl_we;

  assign beat   = in_valid & in_ready;
  assign at_max = (idx == IW'(NUM_VARS - 1));
  assign done   = beat & (in_last | at_max);
  assign early  = in_last & ~at_max;
  assign pass   = TAUT | ((lo <= in_data) & (in_data <= hi));
  assign tbl_we = cfg_we & (state == IDLE) & ~beat;

  split_bound_table #(
    .NUM_VARS (NUM_VARS),
    .VAR_W    (VAR_W)
  ) u_tbl (
    .clk    (clk),
    .rst    (rst),
    .we     (tbl_we),
    .wr_idx (cfg_idx),
    .wr_lo  (cfg_lo),
    .wr_hi  (cfg_hi),
    .rd_idx (idx),
    .rd_lo  (lo),
    .rd_hi  (hi)
  );

  // evaluation FSM with registered handshake and result outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= IDLE;
      idx          <= '0;
      in_ready     <= 1'b1;
      res_valid    <= 1'b0;
      res_x        <= 1'b1;
      res_fail_idx <= '0;
      res_err      <= 1'b0;
    end else begin
      unique case (state)
        IDLE, RUN: begin
          if (beat) begin
            if (res_x & ~pass)
              res_fail_idx <= idx;
            res_x <= res_x & pass & ~(~TAUT & early);
            if (done) begin
              state     <= HOLD;
              in_ready  <= 1'b0;
              res_valid <= 1'b1;
              res_err   <= in_last ^ at_max;
            end else begin
              state <= RUN;
              idx   <= idx + 1'b1;
            end
          end
        end
        HOLD: begin
          if (res_ready) begin
            state        <= IDLE;
            idx          <= '0;
            in_ready     <= 1'b1;
            res_valid    <= 1'b0;
            res_x        <= 1'b1;
            res_fail_idx <= '0;
            res_err      <= 1'b0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
